// File: rtl/int_ctrl_if.sv
// Bundle of interrupt-controller signals between the processor side (master)
// and the controller (slave).
interface int_ctrl_if #(
  parameter int NSRC = 4
);
  logic [NSRC-1:0] irq_in;
  logic            int_en;
  logic            int_ack;
  logic            mask_we;
  logic [NSRC-1:0] mask_d;
  logic            int_req;
  logic [1:0]      int_id;
  logic [NSRC-1:0] pending;
  logic            busy;

  modport master (
    output irq_in, int_en, int_ack, mask_we, mask_d,
    input  int_req, int_id, pending, busy
  );

  modport slave (
    input  irq_in, int_en, int_ack, mask_we, mask_d,
    output int_req, int_id, pending, busy
  );
endinterface

// File: rtl/int_ctrl.sv
// Rising-edge interrupt controller: latched pending flags, enable mask,
// fixed lowest-index priority and a non-nesting IDLE/REQ/SERV handshake.
module int_ctrl #(
  parameter int NSRC = 4  // int_id is 2 bits wide, so at most 4 sources
) (
  input  logic       ck,
  input  logic       res,
  int_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    SERV = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] irq_d_q;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] irq_edge, clr_w, cand_w;
  logic [1:0]      int_id_q, int_id_d, win_id;
  logic            en_prev_q;

  assign cand_w = pending_q & mask_q;

  // A set on the same clock as the acknowledge clear wins.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign irq_edge[gi]  = bus.irq_in[gi] & ~irq_d_q[gi];
    assign pending_d[gi] = irq_edge[gi] | (pending_q[gi] & ~clr_w[gi]);
  end

  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand_w[i]) win_id = 2'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    clr_w    = '0;
    case (state_q)
      IDLE: begin
        if (bus.int_en && (cand_w != '0)) begin
          state_d  = REQ;
          int_id_d = win_id;
        end
      end
      REQ: begin
        // Acknowledge beats a simultaneous withdrawal of int_en.
        if (bus.int_ack) begin
          state_d         = SERV;
          clr_w[int_id_q] = 1'b1;
        end else if (!bus.int_en) begin
          state_d = IDLE;
        end
      end
      SERV: begin
        if (bus.int_en && !en_prev_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (res) begin
      state_q   <= IDLE;
      irq_d_q   <= '0;
      mask_q    <= '0;
      pending_q <= '0;
      int_id_q  <= '0;
      en_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_d_q   <= bus.irq_in;
      pending_q <= pending_d;
      int_id_q  <= int_id_d;
      en_prev_q <= bus.int_en;
      if (bus.mask_we) mask_q <= bus.mask_d;
    end
  end

  assign bus.int_req = (state_q == REQ);
  assign bus.busy    = (state_q == SERV);
  assign bus.int_id  = int_id_q;
  assign bus.pending = pending_q;

endmodule
